// File: rtl/irq_msg_sink_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_msg_sink_if : PIMC interrupt message bus (notify/lineno/id/ack)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface irq_msg_sink_if;
  logic       notify;
  logic [7:0] lineno;
  logic [7:0] processor_id;
  logic       irqack;

  modport master (output notify, lineno, processor_id, input irqack);
  modport slave  (input notify, lineno, processor_id, output irqack);
endinterface
`default_nettype wire

// File: rtl/irq_msg_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_msg_sink : per-core PIMC message claimer with pending-vector FIFO|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irq_msg_sink #(
  parameter logic [7:0] CPU_ID     = 8'h00,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  irq_msg_sink_if.slave               bus,
  input  logic                        rx_en,
  output logic                        irq_pending,
  output logic [7:0]                  irq_vector,
  input  logic                        irq_take,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        stall
);

  localparam int              c_aw   = $clog2(FIFO_DEPTH);
  localparam int              c_cw   = c_aw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic            r_irqack;
  logic            r_pending;
  logic            r_stall;
  logic [7:0]      r_vector;

  logic            w_claim;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [c_cw-1:0] w_left;
  logic [c_cw-1:0] w_count_nxt;
  logic [c_aw-1:0] w_rd_nxt;
  logic [7:0]      w_head_nxt;

  assign w_claim = rx_en & ~bus.notify & (bus.processor_id == CPU_ID);
  // Fullness is judged on the count at the start of the cycle, so a
  // simultaneous take does not open room for a claim until the next cycle.
  assign w_full  = (r_count == c_full);
  assign w_push  = (r_state == S_IDLE) & w_claim & ~w_full;
  assign w_pop   = irq_take & r_pending;
  assign w_left  = r_count - {{(c_cw-1){1'b0}}, w_pop};
  assign w_rd_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // The entry being written this cycle becomes the head when nothing else remains.
  always_comb begin
    w_head_nxt = 8'h00;
    if (w_count_nxt != '0) begin
      if (w_push && (w_left == '0)) begin
        w_head_nxt = bus.lineno;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.lineno;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_irqack  <= 1'b0;
      r_pending <= 1'b0;
      r_stall   <= 1'b0;
      r_vector  <= 8'h00;
    end else begin
      r_count   <= w_count_nxt;
      r_pending <= (w_count_nxt != '0);
      r_vector  <= w_head_nxt;
      r_rd_ptr  <= w_rd_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_irqack <= w_push;
          r_stall  <= w_claim & w_full;
          if (w_push) begin
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_irqack <= 1'b0;
          r_stall  <= 1'b0;
          r_state  <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          // Hold off until PIMC releases the bus so the same message is not claimed twice.
          r_irqack <= 1'b0;
          r_stall  <= 1'b0;
          if (bus.notify) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_irqack <= 1'b0;
          r_stall  <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.irqack  = r_irqack;
  assign irq_pending = r_pending;
  assign irq_vector  = r_vector;
  assign fifo_count  = r_count;
  assign stall       = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_irq_msg_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irq_msg_sink : vector table plus scoreboarded corner sequences    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_irq_msg_sink;

  localparam logic [7:0] CPU   = 8'h21;
  localparam logic [7:0] OTHER = 8'h22;
  localparam int         DEPTH = 8;
  localparam int         NROWS = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b1;
  logic       irq_take = 1'b0;
  logic       irq_pending;
  logic [7:0] irq_vector;
  logic [3:0] fifo_count;
  logic       stall;

  irq_msg_sink_if bus_if ();

  irq_msg_sink #(.CPU_ID(CPU), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .rx_en       (rx_en),
    .irq_pending (irq_pending),
    .irq_vector  (irq_vector),
    .irq_take    (irq_take),
    .fifo_count  (fifo_count),
    .stall       (stall)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       notify;
    logic [7:0] id;
    logic [7:0] ln;
    logic       rx;
    logic       take;
    logic       ack_e;
    logic       pend_e;
    logic [7:0] vec_e;
    logic [3:0] cnt_e;
    logic       stall_e;
  } vec_t;

  vec_t       tbl [NROWS];
  logic [7:0] exp_q [$];
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs; a take on a non-empty FIFO is checked against the scoreboard.
  task automatic cyc(input logic n, input logic [7:0] id, input logic [7:0] ln,
                     input logic rx, input logic tk);
    bus_if.notify       = n;
    bus_if.processor_id = id;
    bus_if.lineno       = ln;
    rx_en               = rx;
    irq_take            = tk;
    if (tk && irq_pending && rst_n) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL pop_vec: got 0x%0h expected <queue empty>", irq_vector);
      end else begin
        chk("pop_vec", {24'h0, irq_vector}, {24'h0, exp_q.pop_front()});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input logic [7:0] ln);
    exp_q.push_back(ln);
    cyc(1'b0, CPU, ln, 1'b1, 1'b0);
    chk("send_ack", {31'h0, bus_if.irqack}, 32'h1);
    cyc(1'b1, CPU, ln, 1'b1, 1'b0);
    cyc(1'b1, CPU, ln, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] outs();
    return {17'h0, bus_if.irqack, irq_pending, irq_vector, fifo_count, stall};
  endfunction

  initial begin
    //              n    id    ln    rx   tk   ack  pnd  vec    cnt   stl
    tbl[0]  = '{1'b1, CPU,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, CPU,  8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[2]  = '{1'b0, CPU,  8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[3]  = '{1'b0, CPU,  8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[4]  = '{1'b0, CPU,  8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[5]  = '{1'b0, CPU,  8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[6]  = '{1'b0, CPU,  8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[7]  = '{1'b0, CPU,  8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[8]  = '{1'b1, CPU,  8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[9]  = '{1'b0, CPU,  8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[10] = '{1'b0, OTHER,8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1, 1'b0};
    tbl[11] = '{1'b1, CPU,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[12] = '{1'b1, CPU,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[13] = '{1'b0, CPU,  8'h09, 1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 4'd1, 1'b0};
    tbl[14] = '{1'b1, CPU,  8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 8'h09, 4'd1, 1'b0};
    tbl[15] = '{1'b1, CPU,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h09, 4'd1, 1'b0};
    tbl[16] = '{1'b0, CPU,  8'h0A, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0A, 4'd1, 1'b0};
    tbl[17] = '{1'b1, CPU,  8'h0A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0A, 4'd1, 1'b0};
    tbl[18] = '{1'b1, CPU,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0A, 4'd1, 1'b0};
    tbl[19] = '{1'b1, CPU,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0};

    bus_if.notify       = 1'b1;
    bus_if.processor_id = 8'h00;
    bus_if.lineno       = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NROWS; i++) begin
      if (tbl[i].ack_e) exp_q.push_back(tbl[i].ln);
      cyc(tbl[i].notify, tbl[i].id, tbl[i].ln, tbl[i].rx, tbl[i].take);
      chk($sformatf("row%0d", i), outs(),
          {17'h0, tbl[i].ack_e, tbl[i].pend_e, tbl[i].vec_e, tbl[i].cnt_e, tbl[i].stall_e});
    end

    // Another core's message held for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, OTHER, 8'h33, 1'b1, 1'b0);
      chk("other_id", {27'h0, bus_if.irqack, fifo_count}, 32'h0);
    end
    cyc(1'b1, CPU, 8'h00, 1'b1, 1'b0);

    // Fill to full, then a ninth message stalls until a take frees a slot.
    for (int i = 3; i <= 10; i++) send_msg(8'(i));
    chk("full_count", {28'h0, fifo_count}, 32'd8);
    chk("full_head", {24'h0, irq_vector}, 32'h03);
    cyc(1'b0, CPU, 8'd11, 1'b1, 1'b0);
    chk("stall_1", {26'h0, bus_if.irqack, stall, fifo_count}, {26'h0, 1'b0, 1'b1, 4'd8});
    cyc(1'b0, CPU, 8'd11, 1'b1, 1'b0);
    chk("stall_2", {26'h0, bus_if.irqack, stall, fifo_count}, {26'h0, 1'b0, 1'b1, 4'd8});
    cyc(1'b0, CPU, 8'd11, 1'b1, 1'b1);
    chk("full_take", {26'h0, bus_if.irqack, stall, fifo_count}, {26'h0, 1'b0, 1'b1, 4'd7});
    exp_q.push_back(8'd11);
    cyc(1'b0, CPU, 8'd11, 1'b1, 1'b0);
    chk("late_claim", {26'h0, bus_if.irqack, stall, fifo_count}, {26'h0, 1'b1, 1'b0, 4'd8});
    cyc(1'b1, CPU, 8'd11, 1'b1, 1'b0);
    cyc(1'b1, CPU, 8'd11, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, CPU, 8'h00, 1'b1, 1'b1);
    chk("drained", outs(), 32'h0);

    // Push and take in the same cycle with two entries queued.
    send_msg(8'h20);
    send_msg(8'h30);
    exp_q.push_back(8'h40);
    cyc(1'b0, CPU, 8'h40, 1'b1, 1'b1);
    chk("pushpop", {27'h0, bus_if.irqack, fifo_count}, {27'h0, 1'b1, 4'd2});
    chk("pushpop_head", {24'h0, irq_vector}, 32'h30);
    cyc(1'b1, CPU, 8'h40, 1'b1, 1'b0);
    cyc(1'b1, CPU, 8'h40, 1'b1, 1'b0);
    cyc(1'b1, CPU, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, CPU, 8'h00, 1'b1, 1'b1);
    chk("pushpop_drain", {28'h0, fifo_count}, 32'h0);

    // Reset while acknowledging; the still-held message is claimed again afterwards.
    exp_q.push_back(8'h55);
    cyc(1'b0, CPU, 8'h55, 1'b1, 1'b0);
    chk("pre_rst_ack", {31'h0, bus_if.irqack}, 32'h1);
    rst_n = 1'b0;
    cyc(1'b0, CPU, 8'h55, 1'b1, 1'b0);
    chk("mid_rst", outs(), 32'h0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(8'h55);
    cyc(1'b0, CPU, 8'h55, 1'b1, 1'b0);
    chk("reclaim", outs(), {17'h0, 1'b1, 1'b1, 8'h55, 4'd1, 1'b0});
    cyc(1'b1, CPU, 8'h55, 1'b1, 1'b0);
    cyc(1'b1, CPU, 8'h55, 1'b1, 1'b0);
    cyc(1'b1, CPU, 8'h00, 1'b1, 1'b1);
    chk("final_empty", outs(), 32'h0);
    chk("sb_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
